// File: rtl/lbm_pkg.sv
// Shared constants and types for the LBM fixed-point datapath.
// Q-format and saturation limits live here so every stage agrees on them.
package lbm_pkg;

  localparam int WIDTH  = 64;
  localparam int FRAC   = 32;
  localparam int Q_DIRS = 9;
  localparam int DIR_W  = $clog2(Q_DIRS);

  localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(1) << FRAC;
  localparam logic signed [WIDTH-1:0] HALF = ONE >>> 1;

  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef logic [DIR_W-1:0] dir_t;

endpackage

// File: rtl/fxp_sat.sv
// Combinational clamp of a signed value of any width down to OUT_W bits,
// with a flag raised whenever the clamp changed the value.
module fxp_sat #(
  parameter int IN_W  = 130,
  parameter int OUT_W = 64
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  // The value fits when every bit from the MSB down to the target sign bit agrees.
  logic [IN_W-OUT_W:0] top_bits;
  assign top_bits = din[IN_W-1:OUT_W-1];

  always_comb begin
    sat  = !((&top_bits) || !(|top_bits));
    dout = din[OUT_W-1:0];
    if (sat) begin
      dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/lbm_relax.sv
// BGK relaxation stage: f_out = f + omega*(feq - f), three registered stages
// with a single global enable so a downstream stall freezes the whole pipe.
module lbm_relax
  import lbm_pkg::*;
(
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  input  logic signed [WIDTH-1:0] F_In,
  input  logic signed [WIDTH-1:0] Feq_In,
  input  logic signed [WIDTH-1:0] Omega,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic signed [WIDTH-1:0] F_Out,
  output dir_t                    Dir_Out,
  output logic                    Cell_Done,
  output logic                    Sat_Flag
);

  localparam int   PROD_W   = 2*WIDTH + 1;
  localparam int   SUM_W    = PROD_W + 1;
  localparam dir_t LAST_DIR = dir_t'(Q_DIRS - 1);

  logic en, accept;
  dir_t dir_cnt;

  logic                    s1_valid;
  logic signed [WIDTH-1:0] s1_f, s1_omega;
  logic signed [WIDTH:0]   s1_diff;
  dir_t                    s1_dir;

  logic                     s2_valid;
  logic signed [WIDTH-1:0]  s2_f;
  logic signed [PROD_W-1:0] s2_scaled;
  dir_t                     s2_dir;

  logic signed [WIDTH:0]    diff;
  logic signed [PROD_W-1:0] prod, scaled;
  logic signed [SUM_W-1:0]  sum;
  logic signed [WIDTH-1:0]  sum_sat;
  logic                     sum_is_sat;

  assign en       = !Out_Valid || Out_Ready;
  assign In_Ready = en;
  assign accept   = In_Valid && en;

  assign diff = {Feq_In[WIDTH-1], Feq_In} - {F_In[WIDTH-1], F_In};
  // NOTE: both operands are sign-extended to the full product width before the
  // multiply; multiplying at operand width would silently drop the high half.
  assign prod   = PROD_W'(s1_omega) * PROD_W'(s1_diff);
  assign scaled = prod >>> FRAC;
  assign sum    = SUM_W'(s2_f) + SUM_W'(s2_scaled);

  fxp_sat #(.IN_W(SUM_W), .OUT_W(WIDTH)) u_sat (
    .din  (sum),
    .dout (sum_sat),
    .sat  (sum_is_sat)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dir_cnt   <= '0;
      s1_valid  <= 1'b0;
      s1_f      <= '0;
      s1_omega  <= '0;
      s1_diff   <= '0;
      s1_dir    <= '0;
      s2_valid  <= 1'b0;
      s2_f      <= '0;
      s2_scaled <= '0;
      s2_dir    <= '0;
      Out_Valid <= 1'b0;
      F_Out     <= '0;
      Dir_Out   <= '0;
      Cell_Done <= 1'b0;
      Sat_Flag  <= 1'b0;
    end else begin
      if (accept) begin
        dir_cnt <= (dir_cnt == LAST_DIR) ? '0 : dir_cnt + 1'b1;
      end
      if (en) begin
        s1_valid  <= accept;
        s2_valid  <= s1_valid;
        Out_Valid <= s2_valid;
        // NOTE: payload registers load only behind a valid word, so bubbles
        // leave F_Out/Dir_Out holding the last delivered result.
        if (accept) begin
          s1_f     <= F_In;
          s1_omega <= Omega;
          s1_diff  <= diff;
          s1_dir   <= dir_cnt;
        end
        if (s1_valid) begin
          s2_f      <= s1_f;
          s2_scaled <= scaled;
          s2_dir    <= s1_dir;
        end
        if (s2_valid) begin
          F_Out   <= sum_sat;
          Dir_Out <= s2_dir;
          if (sum_is_sat) Sat_Flag <= 1'b1;
        end
      end
      Cell_Done <= Out_Valid && Out_Ready && (Dir_Out == LAST_DIR);
    end
  end

endmodule
